cla_16bit_lcu: RTL and testbench
================================

# cla_16bit_lcu

Registered 16-bit carry-look-ahead adder built from four 4-bit CLA slices and a second-level lookahead carry unit (LCU). It produces the sum, the carry-out, and 16-bit block propagate/generate signals, so it can act as a slice of a wider hierarchical adder. The add is single-cycle combinational logic; all outputs are captured in one output register stage.

## Interface
- No parameters. Width is fixed at 16 bits, organised as 4 × 4-bit slices.
- clk  in  1  clock; all outputs update on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in1_16bit  in  16  addend A, unsigned.
- in2_16bit  in  16  addend B, unsigned.
- cin  in  1  carry-in.
- sum_16bit  out  16  registered (A + B + cin) mod 2^16.
- cout  out  1  registered carry-out of bit 15.
- P_16bit  out  1  registered block propagate, p0 & p1 & … & p15, where pi = ai ^ bi.
- G_16bit  out  1  registered block generate: a carry is generated within the block independent of cin.

## Operation
- Per bit: pi = ai ^ bi, gi = ai & bi.
- Each 4-bit slice k computes:
  - lookahead carries from its slice carry-in;
  - slice sums: si = pi ^ ci;
  - slice block signals: Pk = &p[4k+3:4k], Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0 (indices local to the slice).
- LCU computes the slice carry-ins c4, c8, c12 and c16 from cin, P0..P3 and G0..G3 in two-level sum-of-products form. No ripple through slices.
- P_16bit = P3P2P1P0.
- G_16bit = G3 | P3G2 | P3P2G1 | P3P2P1G0.
- cout = c16 = G_16bit | (P_16bit & cin).
- P_16bit and G_16bit are mutually exclusive; both may be 0.
- Overflow wraps: the sum is truncated to 16 bits and the carry appears on cout. There is no signed overflow flag.

## Timing
- On each rising clk edge, all four outputs register the combinational result of the inputs present at that edge. Latency is 1 cycle.
- No handshake. New operands are accepted every cycle.
- rst_n low forces sum_16bit, cout, P_16bit and G_16bit to 0 immediately, without waiting for a clock edge.
- While rst_n is low, outputs hold 0.
- After rst_n deasserts, the first rising edge registers the current inputs.
- If reset asserts mid-stream, the pending result is discarded. No state is retained beyond the output register.
- Inputs must be stable for setup/hold around the rising edge. The combinational path must close at the target clock.

## Structure
- Shared package: constant for the word width (16) and slice width (4). No typedefs are needed.
- Sub-module cla_4bit_pg:
  - inputs: 4-bit a, b and carry-in;
  - outputs: 4-bit sum, block P and block G.
  - The top instantiates it 4 times.
- Sub-module lcu_4: maps cin, P[3:0], G[3:0] to c4, c8, c12, c16, P_16bit and G_16bit.
- The top level contains only the instances plus the output register with asynchronous reset.

## Test plan
Each case: apply inputs, clock once, then check registered outputs.

- Reset:
  - hold rst_n = 0 with arbitrary inputs → sum = 0, cout = 0, P = 0, G = 0, both before and after clock edges;
  - release rst_n → results start on the next edge.
- 30037 + 30049, cin = 0 → sum = 60086, cout = 0, G = 0.
- 1024 + 2048, cin = 0 → sum = 3072, cout = 0, P = 0, G = 0.
- 32768 + 65535, cin = 0 → sum = 32767, cout = 1, P = 0, G = 1.
- 65535 + 65535, cin = 0 → sum = 65534, cout = 1, P = 0, G = 1.
- 462 + 391:
  - cin = 0 → sum = 853, cout = 0;
  - cin = 1 → sum = 854, cout = 0.
- Full-propagate chain, 0xFFFF + 0x0000:
  - cin = 1 → sum = 0, cout = 1, P = 1, G = 0;
  - cin = 0 → sum = 65535, cout = 0, P = 1.
- Back-to-back operands on consecutive cycles → each result appears exactly 1 cycle after its inputs.

Source files
------------

// File: rtl/cla_16bit_lcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_16bit_lcu_pkg
//  Description : Shared width constants for the 16-bit hierarchical CLA.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_16bit_lcu_pkg;
  localparam int c_WORD_W     = 16;
  localparam int c_SLICE_W    = 4;
  localparam int c_NUM_SLICES = c_WORD_W / c_SLICE_W;
endpackage : cla_16bit_lcu_pkg
`default_nettype wire

// File: rtl/cla_16bit_lcu_cla_4bit_pg.sv
`default_nettype none
// ============================================================================
//  Module      : cla_4bit_pg
//  Description : 4-bit carry-lookahead slice producing the sum plus block
//                propagate/generate for a second-level lookahead unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_4bit_pg
  import cla_16bit_lcu_pkg::*;
(
  input  logic [c_SLICE_W-1:0] i_a,
  input  logic [c_SLICE_W-1:0] i_b,
  input  logic                 i_cin,
  output logic [c_SLICE_W-1:0] o_sum,
  output logic                 o_p,
  output logic                 o_g
);

  logic [c_SLICE_W-1:0] w_p;
  logic [c_SLICE_W-1:0] w_g;
  logic [c_SLICE_W-1:0] w_c;

  // Bit propagate/generate, flat lookahead carries and slice block terms
  always_comb begin
    w_p = i_a ^ i_b;
    w_g = i_a & i_b;

    // Every carry is a two-level sum of products from the slice carry-in
    w_c[0] = i_cin;
    w_c[1] = w_g[0] | (w_p[0] & i_cin);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    o_sum = w_p ^ w_c;
    o_p   = &w_p;
    o_g   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
          | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
  end

endmodule : cla_4bit_pg
`default_nettype wire

// File: rtl/cla_16bit_lcu_lcu_4.sv
`default_nettype none
// ============================================================================
//  Module      : lcu_4
//  Description : Second-level lookahead carry unit over four slices; yields
//                the slice carry-ins and the 16-bit block P/G.
//  Revision    : 1.0 - initial release
// ============================================================================
module lcu_4
  import cla_16bit_lcu_pkg::*;
(
  input  logic                    i_cin,
  input  logic [c_NUM_SLICES-1:0] i_p,
  input  logic [c_NUM_SLICES-1:0] i_g,
  output logic                    o_c4,
  output logic                    o_c8,
  output logic                    o_c12,
  output logic                    o_c16,
  output logic                    o_p16,
  output logic                    o_g16
);

  // Slice carries in flat sum-of-products form so no carry ripples across slices
  always_comb begin
    o_c4  = i_g[0] | (i_p[0] & i_cin);
    o_c8  = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    o_c12 = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
          | (i_p[2] & i_p[1] & i_p[0] & i_cin);
    o_p16 = &i_p;
    o_g16 = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
          | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    o_c16 = o_g16 | (o_p16 & i_cin);
  end

endmodule : lcu_4
`default_nettype wire

// File: rtl/cla_16bit_lcu.sv
`default_nettype none
// ============================================================================
//  Module      : cla_16bit_lcu
//  Description : Registered 16-bit two-level carry-lookahead adder with
//                block propagate/generate outputs for wider hierarchies.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_16bit_lcu
  import cla_16bit_lcu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [c_WORD_W-1:0] in1_16bit,
  input  logic [c_WORD_W-1:0] in2_16bit,
  input  logic                cin,
  output logic [c_WORD_W-1:0] sum_16bit,
  output logic                cout,
  output logic                P_16bit,
  output logic                G_16bit
);

  // w_carry[k] is the carry into slice k; w_carry[c_NUM_SLICES] is c16
  logic [c_NUM_SLICES:0]   w_carry;
  logic [c_WORD_W-1:0]     w_sum;
  logic [c_NUM_SLICES-1:0] w_p;
  logic [c_NUM_SLICES-1:0] w_g;
  logic                    w_p16;
  logic                    w_g16;

  logic [c_WORD_W-1:0]     r_sum;
  logic                    r_cout;
  logic                    r_p16;
  logic                    r_g16;

  assign w_carry[0] = cin;

  generate
    for (genvar k = 0; k < c_NUM_SLICES; k++) begin : g_slice
      cla_4bit_pg u_slice (
        .i_a   (in1_16bit[k*c_SLICE_W +: c_SLICE_W]),
        .i_b   (in2_16bit[k*c_SLICE_W +: c_SLICE_W]),
        .i_cin (w_carry[k]),
        .o_sum (w_sum[k*c_SLICE_W +: c_SLICE_W]),
        .o_p   (w_p[k]),
        .o_g   (w_g[k])
      );
    end
  endgenerate

  lcu_4 u_lcu (
    .i_cin (cin),
    .i_p   (w_p),
    .i_g   (w_g),
    .o_c4  (w_carry[1]),
    .o_c8  (w_carry[2]),
    .o_c12 (w_carry[3]),
    .o_c16 (w_carry[4]),
    .o_p16 (w_p16),
    .o_g16 (w_g16)
  );

  // Single output register stage; reset clears it without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_p16  <= 1'b0;
      r_g16  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry[c_NUM_SLICES];
      r_p16  <= w_p16;
      r_g16  <= w_g16;
    end
  end

  assign sum_16bit = r_sum;
  assign cout      = r_cout;
  assign P_16bit   = r_p16;
  assign G_16bit   = r_g16;

endmodule : cla_16bit_lcu
`default_nettype wire

// File: tb/tb_cla_16bit_lcu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_16bit_lcu
//  Description : Self-checking bench for cla_16bit_lcu: stimulus pushes
//                reference results into a queue, a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_16bit_lcu;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        p;
    logic        g;
    int          id;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] in1_16bit;
  logic [15:0] in2_16bit;
  logic        cin;
  logic [15:0] sum_16bit;
  logic        cout;
  logic        P_16bit;
  logic        G_16bit;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_issued = 0;

  cla_16bit_lcu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1_16bit (in1_16bit),
    .in2_16bit (in2_16bit),
    .cin       (cin),
    .sum_16bit (sum_16bit),
    .cout      (cout),
    .P_16bit   (P_16bit),
    .G_16bit   (G_16bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer addition; block G is "carry out with cin forced to 0"
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t        e;
    logic [16:0] full;
    logic [16:0] nocin;
    full   = {1'b0, a} + {1'b0, b} + {16'd0, c};
    nocin  = {1'b0, a} + {1'b0, b};
    e.sum  = full[15:0];
    e.cout = full[16];
    e.p    = ((a ^ b) == 16'hFFFF);
    e.g    = nocin[16];
    e.id   = 0;
    return e;
  endfunction

  task automatic check1(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, required 0x%04h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check1({tag, " sum"},  sum_16bit, 16'd0);
    check1({tag, " cout"}, {15'd0, cout}, 16'd0);
    check1({tag, " P"},    {15'd0, P_16bit}, 16'd0);
    check1({tag, " G"},    {15'd0, G_16bit}, 16'd0);
  endtask

  // Drive one operand pair at the falling edge and queue its expected result
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    @(negedge clk);
    in1_16bit = a;
    in2_16bit = b;
    cin       = c;
    e         = model(a, b, c);
    e.id      = n_issued;
    n_issued++;
    q_exp.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (q_exp.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still outstanding, required 0", q_exp.size());
      q_exp.delete();
    end
  endtask

  // Monitor: every result must appear exactly one edge after its operands
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n && q_exp.size() != 0) begin
      e = q_exp.pop_front();
      check1($sformatf("op%0d sum", e.id),  sum_16bit, e.sum);
      check1($sformatf("op%0d cout", e.id), {15'd0, cout},    {15'd0, e.cout});
      check1($sformatf("op%0d P", e.id),    {15'd0, P_16bit}, {15'd0, e.p});
      check1($sformatf("op%0d G", e.id),    {15'd0, G_16bit}, {15'd0, e.g});
    end
  end

  initial begin
    logic [15:0] a;
    logic [15:0] b;

    // Reset held with arbitrary inputs: outputs zero before and after edges
    rst_n     = 1'b0;
    in1_16bit = 16'hBEEF;
    in2_16bit = 16'hCAFE;
    cin       = 1'b1;
    #2;
    check_zero("reset pre-edge");
    repeat (3) begin
      @(negedge clk);
      in1_16bit = 16'($urandom);
      in2_16bit = 16'($urandom);
      cin       = 1'($urandom);
    end
    @(posedge clk);
    #1;
    check_zero("reset post-edge");

    // Release at the falling edge; first operand is captured on the next rising edge
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the operating envelope (back-to-back issue)
    issue(16'd30037, 16'd30049, 1'b0);
    issue(16'd1024,  16'd2048,  1'b0);
    issue(16'd32768, 16'd65535, 1'b0);
    issue(16'd65535, 16'd65535, 1'b0);
    issue(16'd462,   16'd391,   1'b0);
    issue(16'd462,   16'd391,   1'b1);
    issue(16'hFFFF,  16'h0000,  1'b1);
    issue(16'hFFFF,  16'h0000,  1'b0);
    issue(16'h0000,  16'h0000,  1'b1);
    issue(16'h00F0,  16'h0F0F,  1'b1);
    wait_drain(10);

    // Random traffic, half of it steered towards long propagate chains
    for (int i = 0; i < 300; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 2 == 1) b = ~a ^ (16'(1) << $urandom_range(0, 15)) & 16'($urandom);
      issue(a, b, 1'($urandom));
    end
    wait_drain(10);

    // Mid-stream reset: captured result is discarded immediately, no clock needed
    @(negedge clk);
    in1_16bit = 16'hFFFF;
    in2_16bit = 16'h0001;
    cin       = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async reset");
    @(posedge clk);
    #1;
    check_zero("reset hold");
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h4321, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1);
    issue(16'h7FFF, 16'h8000, 1'b1);
    wait_drain(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cla_16bit_lcu
`default_nettype wire
